// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - multiplexed 3-digit seven-segment scan driver
//
// Purpose: snapshots three BCD digits once per scan frame and time-multiplexes
// them onto a shared active-low segment bus with per-digit active-low enables.
// Each digit slot opens with a dark gap that suppresses ghosting. Optional
// leading-zero blanking is provided, and invalid codes are shown as a dash.
//
// Ports:
//   clk        - single clock, all logic on posedge
//   reset      - synchronous active-low reset
//   enable     - 1 = scan runs, 0 = scan frozen and display dark
//   blank_lz   - 1 = blank leading zeros (hundreds, then tens)
//   bcd0..2    - ones / tens / hundreds BCD digits
//   seg        - segments {g,f,e,d,c,b,a}, active-low, registered
//   an         - digit enables, active-low, an[i] drives digit i, registered
//   frame_tick - one-cycle pulse following each snapshot edge

module seg7_scan #(
    parameter int SCAN_DIV   = 50000,
    parameter int GAP_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       blank_lz,
    input  logic [3:0] bcd0,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd2,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_tick
);

    localparam int            CW   = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GAP  = CW'(GAP_CYCLES);
    localparam logic [6:0]    OFF  = 7'h7F;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    snap0_q, snap0_d;
    logic [3:0]    snap1_q, snap1_d;
    logic [3:0]    snap2_q, snap2_d;
    logic [2:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          frame_tick_q, frame_tick_d;

    logic [3:0]    cur_code;
    logic          cur_blank;
    logic          cur_valid;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // Digit currently being scanned, taken from the frame snapshot so a
    // mid-frame input change cannot tear the display.
    always_comb begin
        cur_code  = 4'd0;
        cur_valid = 1'b1;
        cur_blank = 1'b0;
        case (idx_q)
            2'd0: cur_code = snap0_q;
            2'd1: begin
                cur_code  = snap1_q;
                cur_blank = blank_lz && (snap2_q == 4'd0) && (snap1_q == 4'd0);
            end
            2'd2: begin
                cur_code  = snap2_q;
                cur_blank = blank_lz && (snap2_q == 4'd0);
            end
            default: cur_valid = 1'b0;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        snap0_d      = snap0_q;
        snap1_d      = snap1_q;
        snap2_d      = snap2_q;
        an_d         = 3'b111;
        seg_d        = OFF;
        frame_tick_d = 1'b0;

        if (enable) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end

            if ((cnt_q == '0) && (idx_q == 2'd0)) begin
                snap0_d      = bcd0;
                snap1_d      = bcd1;
                snap2_d      = bcd2;
                frame_tick_d = 1'b1;
            end

            // Active phase; a blanked digit stays dark like the gap.
            if ((cnt_q >= GAP) && cur_valid && !cur_blank) begin
                an_d  = ~(3'b001 << idx_q);
                seg_d = decode(cur_code);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            snap0_q      <= 4'd0;
            snap1_q      <= 4'd0;
            snap2_q      <= 4'd0;
            an_q         <= 3'b111;
            seg_q        <= OFF;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap0_q      <= snap0_d;
            snap1_q      <= snap1_d;
            snap2_q      <= snap2_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - directed self-checking bench for seg7_scan

module tb_seg7_scan;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       blank_lz;
    logic [3:0] bcd0;
    logic [3:0] bcd1;
    logic [3:0] bcd2;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    seg7_scan #(
        .SCAN_DIV  (8),
        .GAP_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .blank_lz  (blank_lz),
        .bcd0      (bcd0),
        .bcd1      (bcd1),
        .bcd2      (bcd2),
        .seg       (seg),
        .an        (an),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and compare outputs at the following negedge.
    task automatic chk(input string tag, input logic [2:0] ea, input logic [6:0] es,
                       input logic ef);
        @(negedge clk);
        checks++;
        assert ({an, seg, frame_tick} === {ea, es, ef}) else begin
            errors++;
            $error("FAIL %s: an=%b seg=%h ft=%b, expected an=%b seg=%h ft=%b",
                   tag, an, seg, frame_tick, ea, es, ef);
        end
    endtask

    // One 8-cycle slot: 2 dark gap cycles then 6 active cycles.
    task automatic slot(input string tag, input logic [2:0] ea, input logic [6:0] es,
                        input logic first);
        chk({tag, "_gap0"}, 3'b111, 7'h7F, first);
        chk({tag, "_gap1"}, 3'b111, 7'h7F, 1'b0);
        repeat (6) chk({tag, "_act"}, ea, es, 1'b0);
    endtask

    initial begin
        reset    = 1'b0;
        enable   = 1'b1;
        blank_lz = 1'b0;
        bcd0     = 4'd3;
        bcd1     = 4'd2;
        bcd2     = 4'd1;

        repeat (3) chk("reset_hold", 3'b111, 7'h7F, 1'b0);
        reset = 1'b1;

        // Normal scan 1/2/3, two frames to show repetition.
        slot("f1_d0", 3'b110, 7'h30, 1'b1);
        slot("f1_d1", 3'b101, 7'h24, 1'b0);
        slot("f1_d2", 3'b011, 7'h79, 1'b0);
        slot("f2_d0", 3'b110, 7'h30, 1'b1);
        slot("f2_d1", 3'b101, 7'h24, 1'b0);
        slot("f2_d2", 3'b011, 7'h79, 1'b0);

        // 0/0/7 with leading-zero blanking.
        bcd0 = 4'd7; bcd1 = 4'd0; bcd2 = 4'd0; blank_lz = 1'b1;
        slot("lz_d0", 3'b110, 7'h78, 1'b1);
        slot("lz_d1", 3'b111, 7'h7F, 1'b0);
        slot("lz_d2", 3'b111, 7'h7F, 1'b0);

        // Same digits, blanking off.
        blank_lz = 1'b0;
        slot("nolz_d0", 3'b110, 7'h78, 1'b1);
        slot("nolz_d1", 3'b101, 7'h40, 1'b0);
        slot("nolz_d2", 3'b011, 7'h40, 1'b0);

        // 0/5/0 with blanking: only hundreds blanked, ones zero still shown.
        bcd0 = 4'd0; bcd1 = 4'd5; bcd2 = 4'd0; blank_lz = 1'b1;
        slot("lz050_d0", 3'b110, 7'h40, 1'b1);
        slot("lz050_d1", 3'b101, 7'h12, 1'b0);
        slot("lz050_d2", 3'b111, 7'h7F, 1'b0);

        // Invalid tens code, then inputs change 4 cycles after frame_tick.
        bcd0 = 4'd3; bcd1 = 4'd12; bcd2 = 4'd1;
        chk("inv_gap0", 3'b111, 7'h7F, 1'b1);
        chk("inv_gap1", 3'b111, 7'h7F, 1'b0);
        chk("inv_d0a",  3'b110, 7'h30, 1'b0);
        chk("inv_d0b",  3'b110, 7'h30, 1'b0);
        bcd0 = 4'd6; bcd1 = 4'd8; bcd2 = 4'd9; blank_lz = 1'b0;
        repeat (4) chk("tear_d0", 3'b110, 7'h30, 1'b0);
        slot("tear_d1", 3'b101, 7'h3F, 1'b0);
        slot("tear_d2", 3'b011, 7'h79, 1'b0);

        // New snapshot 9/8/6; freeze in the middle of digit 1's active phase.
        slot("new_d0", 3'b110, 7'h02, 1'b1);
        chk("frz_gap0", 3'b111, 7'h7F, 1'b0);
        chk("frz_gap1", 3'b111, 7'h7F, 1'b0);
        repeat (3) chk("frz_pre", 3'b101, 7'h00, 1'b0);
        enable = 1'b0;
        repeat (5) chk("frz_dark", 3'b111, 7'h7F, 1'b0);
        enable = 1'b1;
        repeat (3) chk("frz_post", 3'b101, 7'h00, 1'b0);
        slot("frz_d2", 3'b011, 7'h10, 1'b0);

        // Reset during digit 2's active phase, restart with fresh inputs.
        slot("rst_d0", 3'b110, 7'h02, 1'b1);
        slot("rst_d1", 3'b101, 7'h00, 1'b0);
        chk("rst_gap0", 3'b111, 7'h7F, 1'b0);
        chk("rst_gap1", 3'b111, 7'h7F, 1'b0);
        repeat (3) chk("rst_pre", 3'b011, 7'h10, 1'b0);
        reset = 1'b0;
        bcd0 = 4'd5; bcd1 = 4'd0; bcd2 = 4'd4; blank_lz = 1'b1;
        repeat (2) chk("rst_dark", 3'b111, 7'h7F, 1'b0);
        reset = 1'b1;
        slot("rs_d0", 3'b110, 7'h12, 1'b1);
        slot("rs_d1", 3'b101, 7'h40, 1'b0);
        slot("rs_d2", 3'b011, 7'h19, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
